mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

  // Default widths, sized to match main_memory.
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 9;

  // Transaction FSM: one access in flight at a time.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Requester ids.
  localparam logic REQ_DP    = 1'b0;  // datapath (MAR/MDR), read/write
  localparam logic REQ_FETCH = 1'b1;  // instruction fetch (PC/MBR), read-only

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick between the datapath and fetch requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a pick becomes a grant.
//
// Ports:
//   req0_i    - datapath request
//   req1_i    - fetch request
//   last_i    - id of the requester granted most recently
//   gnt_vld_o - at least one request is pending
//   gnt_id_o  - id of the winning requester (meaningful only when gnt_vld_o)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_vld_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      // Contention: hand the grant to whoever did not win last time.
      gnt_id_o = ~last_i;
    end else if (req1_i) begin
      gnt_id_o = REQ_FETCH;
    end else begin
      gnt_id_o = REQ_DP;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the datapath and fetch requesters onto main_memory port A, one transaction at a time.
// Latency: request sampled in IDLE -> memory access next cycle -> ack the cycle after (2 cycles); grants >= 3 cycles apart.
// Backpressure: level requests are held until ack; an ungranted request that drops is simply forgotten.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   req0, req0_we, req0_addr, req0_wdata - datapath request (read or write)
//   ack0, rdata0                      - datapath completion pulse and registered read data
//   req1, req1_addr                   - fetch request (read-only)
//   ack1, rdata1                      - fetch completion pulse and registered read data
//   mem_wen, mem_ren, mem_addr, mem_wdata, mem_rdata - main_memory port A (sync read, data one cycle after mem_ren)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q;
  logic              last_q;     // round-robin pointer: id granted most recently
  logic              id_q;       // owner of the in-flight transaction
  logic              we_q;       // in-flight transaction is a write
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              mem_wen_q;
  logic              mem_ren_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              gnt_we_d;

  rr_arb2 u_rr_arb2 (
    .req0_i    (req0),
    .req1_i    (req1),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  // Fetch can never write; req0_we only matters when the datapath wins.
  assign gnt_we_d = (gnt_id == REQ_DP) && req0_we;

  // The mem_* registers double as the address/data latches: they are loaded on
  // grant so they are valid for exactly the ACCESS cycle, and cleared on the
  // way out so port A reads as all-zero in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= REQ_FETCH;  // pretend fetch won last so the datapath is favoured first
      id_q        <= REQ_DP;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            id_q        <= gnt_id;
            last_q      <= gnt_id;
            we_q        <= gnt_we_d;
            mem_wen_q   <= gnt_we_d;
            mem_ren_q   <= ~gnt_we_d;
            mem_addr_q  <= (gnt_id == REQ_FETCH) ? req1_addr : req0_addr;
            mem_wdata_q <= (gnt_id == REQ_DP) ? req0_wdata : '0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wen_q   <= 1'b0;
          mem_ren_q   <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          // Ack is registered here so it is visible during RESP, while the
          // memory's read data is on mem_rdata.
          ack0_q      <= (id_q == REQ_DP);
          ack1_q      <= (id_q == REQ_FETCH);
          state_q     <= RESP;
        end
        RESP: begin
          if (!we_q) begin
            if (id_q == REQ_DP) begin
              rdata0_q <= mem_rdata;
            end else begin
              rdata1_q <= mem_rdata;
            end
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a synchronous-read memory model and a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

  typedef struct {
    bit         id;
    bit         we;
    logic [8:0] addr;
    logic [8:0] wdata;
    logic [8:0] exp_rd;  // value rdataN of that requester must hold after completion
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req0_we;
  logic [8:0] req0_addr;
  logic [8:0] req0_wdata;
  logic       ack0;
  logic [8:0] rdata0;
  logic       req1;
  logic [8:0] req1_addr;
  logic       ack1;
  logic [8:0] rdata1;
  logic       mem_wen;
  logic       mem_ren;
  logic [8:0] mem_addr;
  logic [8:0] mem_wdata;
  logic [8:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [8:0] mem     [512];
  logic [8:0] ref_mem [512];
  logic [8:0] ref_rd0;
  logic [8:0] ref_rd1;
  vec_t       acc_q[$];
  vec_t       ack_q[$];
  bit         mon_en  = 0;
  bit         pend    = 0;
  bit         pend_id = 0;
  logic [8:0] pend_rd = '0;
  int         acc_cnt = 0;

  mem_arbiter #(.ADDR_W(9), .DATA_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .ack0       (ack0),
    .rdata0     (rdata0),
    .req1       (req1),
    .req1_addr  (req1_addr),
    .ack1       (ack1),
    .rdata1     (rdata1),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] init_val(int i);
    return (i == 3) ? 9'h0A5 : 9'(i * 3 + 1);
  endfunction

  // main_memory port A model: contents reload while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    ref_rd0 = '0;
    ref_rd1 = '0;
    acc_q.delete();
    ack_q.delete();
    pend = 0;
  endtask

  // Scoreboard push: computes the expected post-completion rdata from the reference model.
  task automatic push_exp(input vec_t v);
    vec_t e;
    e = v;
    if (v.we) begin
      ref_mem[v.addr] = v.wdata;
      e.exp_rd = ref_rd0;
    end else if (v.id) begin
      ref_rd1  = ref_mem[v.addr];
      e.exp_rd = ref_rd1;
    end else begin
      ref_rd0  = ref_mem[v.addr];
      e.exp_rd = ref_rd0;
    end
    acc_q.push_back(e);
  endtask

  // Monitor / scoreboard pop, sampled on the falling edge.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          pend = 0;
          chk("sb_rdata", 32'(pend_id ? rdata1 : rdata0), 32'(pend_rd));
        end
        chk("wen_ren_excl", 32'(mem_wen & mem_ren), 32'd0);
        chk("ack_excl", 32'(ack0 & ack1), 32'd0);
        if (!(mem_wen | mem_ren)) chk("mem_idle_zero", 32'({mem_addr, mem_wdata}), 32'd0);
        if (mem_wen | mem_ren) begin
          acc_cnt++;
          if (acc_q.size() == 0) begin
            fail("unexpected_access");
          end else begin
            e = acc_q.pop_front();
            chk("acc_we", 32'(mem_wen), 32'(e.we));
            chk("acc_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) chk("acc_wdata", 32'(mem_wdata), 32'(e.wdata));
            ack_q.push_back(e);
          end
        end
        if (ack0 | ack1) begin
          if (ack_q.size() == 0) begin
            fail("unexpected_ack");
          end else begin
            e = ack_q.pop_front();
            chk("ack_id", 32'(ack1), 32'(e.id));
            pend    = 1;
            pend_id = e.id;
            pend_rd = e.exp_rd;
          end
        end
      end
    end
  end

  task automatic do_reset();
    mon_en     = 0;
    rst        = 1'b1;
    req0       = 1'b0;
    req0_we    = 1'b0;
    req0_addr  = '0;
    req0_wdata = '0;
    req1       = 1'b0;
    req1_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_reset();
    mon_en = 1;
  endtask

  task automatic do_txn(input vec_t v, input bit drop_early);
    int lat;
    lat = -1;
    @(posedge clk);
    #1;
    push_exp(v);
    if (v.id) begin
      req1      = 1'b1;
      req1_addr = v.addr;
    end else begin
      req0       = 1'b1;
      req0_we    = v.we;
      req0_addr  = v.addr;
      req0_wdata = v.wdata;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if ((v.id ? ack1 : ack0) === 1'b1) begin
        lat = c;
        break;
      end
      if (drop_early && c == 0) begin
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0    = 1'b0;
    req1    = 1'b0;
    req0_we = 1'b0;
    chk("ack_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("vec_rdata", 32'(v.id ? rdata1 : rdata0), 32'(v.exp_rd));
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    int a0;
    bit ord[4];
    int cyc[4];
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 9'd3,   9'd0,   9'h0A5};
    vecs[1] = '{1'b0, 1'b1, 9'd7,   9'h1FF, 9'h0A5};
    vecs[2] = '{1'b0, 1'b0, 9'd7,   9'd0,   9'h1FF};
    vecs[3] = '{1'b1, 1'b0, 9'd7,   9'd0,   9'h1FF};
    vecs[4] = '{1'b0, 1'b1, 9'd0,   9'h123, 9'h1FF};
    vecs[5] = '{1'b1, 1'b0, 9'd0,   9'd0,   9'h123};
    vecs[6] = '{1'b0, 1'b0, 9'd3,   9'd0,   9'h0A5};
    vecs[7] = '{1'b0, 1'b1, 9'd511, 9'h055, 9'h0A5};
    vecs[8] = '{1'b1, 1'b0, 9'd511, 9'd0,   9'h055};
    vecs[9] = '{1'b0, 1'b0, 9'd10,  9'd0,   9'h01F};

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_mem_en", 32'({mem_wen, mem_ren}), 32'd0);
    chk("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);

    // Both requesters held from reset: datapath first, then strict alternation.
    @(posedge clk);
    #1;
    push_exp('{1'b0, 1'b0, 9'd3, 9'd0, 9'd0});
    push_exp('{1'b1, 1'b0, 9'd7, 9'd0, 9'd0});
    push_exp('{1'b0, 1'b0, 9'd3, 9'd0, 9'd0});
    push_exp('{1'b1, 1'b0, 9'd7, 9'd0, 9'd0});
    req0 = 1'b1; req0_we = 1'b0; req0_addr = 9'd3;
    req1 = 1'b1; req1_addr = 9'd7;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        ord[n] = ack1;
        cyc[n] = c;
        n++;
        if (n == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_grants", 32'(n), 32'd4);
    if (n == 4) begin
      chk("rr_first_ack", 32'(cyc[0]), 32'd2);
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", 32'(ord[k]), 32'(k % 2));
        if (k > 0) chk("rr_spacing", 32'(cyc[k] - cyc[k-1]), 32'd3);
      end
    end

    // Table of single transactions.
    for (int i = 0; i < 10; i++) do_txn(vecs[i], 1'b0);

    // Fetch request dropped right after grant still completes, exactly once.
    a0 = acc_cnt;
    v = '{1'b1, 1'b0, 9'd4, 9'd0, 9'h00D};
    do_txn(v, 1'b1);
    repeat (4) @(negedge clk);
    chk("drop_single_access", 32'(acc_cnt - a0), 32'd1);

    // Reset in the ACCESS cycle of a datapath read aborts it silently.
    do_reset();
    @(posedge clk);
    #1;
    push_exp('{1'b0, 1'b0, 9'd3, 9'd0, 9'd0});
    req0 = 1'b1; req0_we = 1'b0; req0_addr = 9'd3;
    @(posedge clk);
    #1;
    chk("abort_in_access", 32'(mem_ren), 32'd1);
    rst  = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_ren", 32'(mem_ren), 32'd0);
    chk("abort_rdata0", 32'(rdata0), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_ack0", 32'(ack0), 32'd0);
      @(negedge clk);
    end
    ref_reset();

    // FSM is back in IDLE: a fresh read completes with normal latency.
    v = '{1'b0, 1'b0, 9'd3, 9'd0, 9'h0A5};
    do_txn(v, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
